// File: rtl/osiris_wb_pkg.sv
// Shared definitions for the osiris Wishbone IO slave: bus widths,
// register offsets and the bus-response FSM encoding.
package osiris_wb_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;

  localparam logic [7:0] IO_OUT_OFF  = 8'h00;
  localparam logic [7:0] IO_OEB_OFF  = 8'h04;
  localparam logic [7:0] IO_IN_OFF   = 8'h08;
  localparam logic [7:0] SCRATCH_OFF = 8'h0C;
  localparam logic [7:0] CYCLE_OFF   = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_t;

  // Word-aligned register offset; the byte-lane bits are ignored.
  function automatic logic [7:0] word_off(input logic [7:0] adr);
    return adr & 8'hFC;
  endfunction

endpackage

// File: rtl/osiris_sync2.sv
// Parameterized-width two-flop synchronizer with async active-low reset.
module osiris_sync2 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back capture stages; q is the resolved copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/osiris_wb_io_slave.sv
// Wishbone classic-cycle register slave: GPIO out/enable, synchronized GPIO
// in, scratch word and free-running cycle counter. Optional macro
// OSIRIS_WB_ERR_EN adds wb_err_o for unmapped or read-only-write accesses.
module osiris_wb_io_slave
  import osiris_wb_pkg::*;
#(
  parameter int unsigned BITS        = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [WB_ADR_W-1:0] wb_adr_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic                wb_ack_o,
  input  logic [BITS-1:0]     io_in,
  output logic [BITS-1:0]     io_out,
  output logic [BITS-1:0]     io_oeb
`ifdef OSIRIS_WB_ERR_EN
  ,
  output logic                wb_err_o
`endif
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_t             state;
  logic [3:0]            wait_cnt;
  logic [7:0]            off_q;
  logic                  we_q;
  logic [WB_DAT_W-1:0]   dat_q;
  logic [WB_DAT_W-1:0]   scratch;
  logic [WB_DAT_W-1:0]   cycle;
  logic [BITS-1:0]       io_sync;

  logic                  req;
  logic                  enter_ack;
  logic [7:0]            sel_off;
  logic                  sel_we;
  logic [WB_DAT_W-1:0]   sel_dat;
  logic [WB_DAT_W-1:0]   rd_data;
  logic                  mapped;
  logic                  bad;
  logic                  do_write;

  osiris_sync2 #(.W(BITS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (io_in),
    .q     (io_sync)
  );

  assign req = wb_cyc_i & wb_stb_i & (wb_adr_i[31:8] == BASE_ADDR[31:8]);

  // With no wait states the ACK edge is the sampling edge itself, so the
  // access uses the live bus; otherwise it uses the copy latched in IDLE.
  assign enter_ack = ((state == ST_IDLE) && req && (WAIT_STATES == 0)) ||
                     ((state == ST_WAIT) && wb_cyc_i && wb_stb_i && (wait_cnt == 4'd0));
  assign sel_off   = (state == ST_IDLE) ? word_off(wb_adr_i[7:0]) : off_q;
  assign sel_we    = (state == ST_IDLE) ? wb_we_i : we_q;
  assign sel_dat   = (state == ST_IDLE) ? wb_dat_i : dat_q;

  // Read mux and decode of the selected offset.
  always_comb begin
    rd_data = '0;
    mapped  = 1'b1;
    case (sel_off)
      IO_OUT_OFF:  rd_data = 32'(io_out);
      IO_OEB_OFF:  rd_data = 32'(io_oeb);
      IO_IN_OFF:   rd_data = 32'(io_sync);
      SCRATCH_OFF: rd_data = scratch;
      CYCLE_OFF:   rd_data = cycle;
      default:     mapped  = 1'b0;
    endcase
  end

`ifdef OSIRIS_WB_ERR_EN
  assign bad      = !mapped || (sel_we && ((sel_off == IO_IN_OFF) || (sel_off == CYCLE_OFF)));
  assign do_write = enter_ack && sel_we && !bad;
`else
  assign bad      = !mapped;
  assign do_write = enter_ack && sel_we;
`endif

  // Bus-response FSM with registered ack/err and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      off_q    <= '0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
`ifdef OSIRIS_WB_ERR_EN
      wb_err_o <= 1'b0;
`endif
    end else begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
`ifdef OSIRIS_WB_ERR_EN
      wb_err_o <= 1'b0;
`endif
      if ((state == ST_IDLE) && req) begin
        off_q <= word_off(wb_adr_i[7:0]);
        we_q  <= wb_we_i;
        dat_q <= wb_dat_i;
      end
      if (enter_ack) begin
        state <= ST_ACK;
`ifdef OSIRIS_WB_ERR_EN
        if (bad) begin
          wb_err_o <= 1'b1;
        end else begin
          wb_ack_o <= 1'b1;
          wb_dat_o <= sel_we ? '0 : rd_data;
        end
`else
        wb_ack_o <= 1'b1;
        wb_dat_o <= (sel_we || bad) ? '0 : rd_data;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (req) begin
              state    <= ST_WAIT;
              wait_cnt <= WS_LOAD;
            end
          end
          ST_WAIT: begin
            if (!(wb_cyc_i && wb_stb_i)) state <= ST_IDLE;
            else                          wait_cnt <= wait_cnt - 4'd1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Register bank writes and the free-running cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_out  <= '0;
      io_oeb  <= '1;
      scratch <= '0;
      cycle   <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (do_write) begin
        case (sel_off)
          IO_OUT_OFF:  io_out  <= sel_dat[BITS-1:0];
          IO_OEB_OFF:  io_oeb  <= sel_dat[BITS-1:0];
          SCRATCH_OFF: scratch <= sel_dat;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osiris_wb_io_slave.sv
// Directed bench for osiris_wb_io_slave: one instance with no wait states,
// one with three, each on its own bus.
module tb_osiris_wb_io_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic [1:0]  ack;
  logic [15:0] io_in;
  logic [15:0] io_out [2];
  logic [15:0] io_oeb [2];
`ifdef OSIRIS_WB_ERR_EN
  logic [1:0]  err;
`endif
  logic [31:0] tcnt;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Reference cycle count: clocks since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 32'd0;
    else        tcnt <= tcnt + 32'd1;
  end

  osiris_wb_io_slave #(.BITS(16), .BASE_ADDR(32'h3000_0000), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]),
    .io_in(io_in), .io_out(io_out[0]), .io_oeb(io_oeb[0])
`ifdef OSIRIS_WB_ERR_EN
    , .wb_err_o(err[0])
`endif
  );

  osiris_wb_io_slave #(.BITS(16), .BASE_ADDR(32'h3000_0000), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]),
    .io_in(io_in), .io_out(io_out[1]), .io_oeb(io_oeb[1])
`ifdef OSIRIS_WB_ERR_EN
    , .wb_err_o(err[1])
`endif
  );

  // One transfer on bus d; lat = cycles from request sample to ack/err (0 = none).
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input int bound, output logic [31:0] rd, output int lat,
                      output logic ackv, output logic errd, output logic early,
                      output logic [31:0] after, output logic ack_after, output logic [31:0] cnt_at);
    logic e;
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd;
    rd = '0; lat = 0; ackv = 1'b0; errd = 1'b0; early = 1'b0; cnt_at = '0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk); #1;
`ifdef OSIRIS_WB_ERR_EN
      e = err[d];
`else
      e = 1'b0;
`endif
      if (ack[d] || e) begin
        lat = i; rd = rdat[d]; ackv = ack[d]; errd = e; cnt_at = tcnt;
        break;
      end
      if (rdat[d] !== 32'd0) early = 1'b1;
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(posedge clk); #1;
    after = rdat[d];
    ack_after = ack[d];
  endtask

  logic [31:0] rd, after, cnt_at;
  int          lat;
  logic        ackv, errd, early, ack_after;

  task automatic test_reset();
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", ack); end
    checks++; if (rdat[0] !== 32'd0) begin errors++; $display("FAIL reset_dat: got %h expected 0", rdat[0]); end
    checks++; if (io_oeb[0] !== 16'hFFFF || io_oeb[1] !== 16'hFFFF) begin errors++; $display("FAIL reset_oeb: got %h/%h expected FFFF", io_oeb[0], io_oeb[1]); end
    checks++; if (io_out[0] !== 16'h0 || io_out[1] !== 16'h0) begin errors++; $display("FAIL reset_out: got %h/%h expected 0", io_out[0], io_out[1]); end
    xfer(0, 1'b0, 32'h3000_0010, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (lat != 1 || rd !== cnt_at - 32'd1 || rd > 32'd8) begin errors++; $display("FAIL reset_cycle: got %h lat %0d expected %h lat 1", rd, lat, cnt_at - 32'd1); end
    // Reset while dut0 acks and dut3 holds a pending write in WAIT.
    @(posedge clk); #1;
    cyc = 2'b11; stb = 2'b11; we = 2'b10;
    adr[0] = 32'h3000_000C; adr[1] = 32'h3000_0000; wdat[1] = 32'h0000_5555;
    @(posedge clk); #1;
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL reset_pre_ack: got %b expected 01", ack); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL reset_async_ack: got %b expected 0", ack[0]); end
    cyc = 2'b00; stb = 2'b00; we = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (io_out[1] !== 16'h0 || ack !== 2'b00) begin errors++; $display("FAIL reset_lost_write: got %h ack %b expected 0 ack 00", io_out[1], ack); end
  endtask

  task automatic test_write_ws0();
    xfer(0, 1'b1, 32'h3000_0000, 32'h0000_A5A5, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (lat != 1 || ack_after !== 1'b0) begin errors++; $display("FAIL ws0_write_lat: got lat %0d ack_after %b expected 1/0", lat, ack_after); end
    checks++; if (io_out[0] !== 16'hA5A5) begin errors++; $display("FAIL ws0_io_out: got %h expected A5A5", io_out[0]); end
    xfer(0, 1'b0, 32'h3000_0000, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (rd !== 32'h0000_A5A5 || lat != 1 || after !== 32'd0) begin errors++; $display("FAIL ws0_readback: got %h lat %0d after %h expected 0000A5A5 1 0", rd, lat, after); end
    xfer(0, 1'b1, 32'h3000_0000, 32'hFFFF_1234, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    xfer(0, 1'b0, 32'h3000_0000, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL ws0_upper_zero: got %h expected 00001234", rd); end
    xfer(0, 1'b1, 32'h3000_0006, 32'h0000_00FF, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (io_oeb[0] !== 16'h00FF) begin errors++; $display("FAIL ws0_byte_lane_ignored: got %h expected 00FF", io_oeb[0]); end
  endtask

  task automatic test_wait_states();
    xfer(1, 1'b1, 32'h3000_000C, 32'hDEAD_BEEF, 12, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (lat != 4) begin errors++; $display("FAIL ws3_write_lat: got %0d expected 4", lat); end
    xfer(1, 1'b0, 32'h3000_000C, 32'd0, 12, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (lat != 4 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws3_read: got %h lat %0d expected DEADBEEF lat 4", rd, lat); end
    checks++; if (early !== 1'b0 || after !== 32'd0 || ack_after !== 1'b0) begin errors++; $display("FAIL ws3_dat_window: got early %b after %h ack_after %b expected 0 0 0", early, after, ack_after); end
  endtask

  task automatic test_io_in();
    io_in = 16'h1234;
    repeat (3) @(posedge clk);
    xfer(0, 1'b0, 32'h3000_0008, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL io_in_settled: got %h expected 00001234", rd); end
    io_in = 16'hABCD;
    xfer(0, 1'b0, 32'h3000_0008, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL io_in_two_stage: got %h expected 00001234", rd); end
    xfer(0, 1'b0, 32'h3000_0008, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (rd !== 32'h0000_ABCD) begin errors++; $display("FAIL io_in_new: got %h expected 0000ABCD", rd); end
  endtask

  task automatic test_abort();
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h3000_0004; wdat[1] = 32'h0000_0F0F;
    repeat (2) begin @(posedge clk); #1; if (ack[1]) seen = 1'b1; end
    stb[1] = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (ack[1]) seen = 1'b1; end
    cyc[1] = 1'b0; we[1] = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got ack %b expected 0", seen); end
    checks++; if (io_oeb[1] !== 16'hFFFF) begin errors++; $display("FAIL abort_no_write: got %h expected FFFF", io_oeb[1]); end
    xfer(1, 1'b0, 32'h3000_0004, 32'd0, 12, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (lat != 4 || rd !== 32'h0000_FFFF) begin errors++; $display("FAIL abort_recover: got %h lat %0d expected 0000FFFF lat 4", rd, lat); end
    xfer(0, 1'b1, 32'h3000_0100, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (lat != 0 || io_out[0] !== 16'h1234) begin errors++; $display("FAIL bad_base: got lat %0d io_out %h expected 0 1234", lat, io_out[0]); end
  endtask

  task automatic test_unmapped();
    xfer(0, 1'b0, 32'h3000_0020, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
`ifdef OSIRIS_WB_ERR_EN
    checks++; if (lat != 1 || ackv !== 1'b0 || errd !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL unmapped_read: got lat %0d ack %b err %b dat %h expected 1 0 1 0", lat, ackv, errd, rd); end
`else
    checks++; if (lat != 1 || ackv !== 1'b1 || errd !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL unmapped_read: got lat %0d ack %b err %b dat %h expected 1 1 0 0", lat, ackv, errd, rd); end
`endif
    xfer(0, 1'b1, 32'h3000_0010, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
`ifdef OSIRIS_WB_ERR_EN
    checks++; if (lat != 1 || errd !== 1'b1 || ackv !== 1'b0) begin errors++; $display("FAIL ro_write_resp: got lat %0d ack %b err %b expected 1 0 1", lat, ackv, errd); end
`else
    checks++; if (lat != 1 || ackv !== 1'b1) begin errors++; $display("FAIL ro_write_resp: got lat %0d ack %b expected 1 1", lat, ackv); end
`endif
    xfer(0, 1'b0, 32'h3000_0010, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (rd !== cnt_at - 32'd1) begin errors++; $display("FAIL cycle_unwritable: got %h expected %h", rd, cnt_at - 32'd1); end
    xfer(0, 1'b1, 32'h3000_0014, 32'h0000_FFFF, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    xfer(0, 1'b0, 32'h3000_0000, 32'd0, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL unmapped_write_discard: got %h expected 00001234", rd); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  pat;
    logic [31:0] d0, d1;
    xfer(0, 1'b1, 32'h3000_000C, 32'h1357_9BDF, 8, rd, lat, ackv, errd, early, after, ack_after, cnt_at);
    @(posedge clk); #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h3000_000C;
    pat = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = ack[0];
      if (i == 0) d0 = rdat[0];
      if (i == 1) d1 = rdat[0];
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    checks++; if (pat !== 4'b0101) begin errors++; $display("FAIL b2b_ack_pattern: got %b expected 0101", pat); end
    checks++; if (d0 !== 32'h1357_9BDF || d1 !== 32'd0) begin errors++; $display("FAIL b2b_data: got %h/%h expected 13579BDF/0", d0, d1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0;
    adr[0] = '0; adr[1] = '0; wdat[0] = '0; wdat[1] = '0;
    io_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_write_ws0();
    test_wait_states();
    test_io_in();
    test_abort();
    test_unmapped();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
